count_event_tx: RTL and testbench

//   Downstream consumer of the 4-bit synchronous up counter. Watches the counter value,

---
 rtl/count_event_tx.sv | 270 +++++++++++++++++++++++++++
 tb/tb_count_event_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_tx.sv
// count_event_tx
//   Watches an upstream counter and raises an event each time the value
//   changes. A change from the all-ones value to zero is tagged as a wrap.
//   Events wait in a small FIFO. A serial transmitter sends each one as a
//   frame on an idle-high line:
//     start(0) | WIDTH data bits, LSB first | tag | stop(1)
//   Each bit lasts BIT_CYCLES clocks.
//   Every output comes straight from a flop.
module count_event_tx #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             sample_en,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             overflow,
    output logic             wrap_pulse
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int EW = WIDTH + 1;   // event word: {tag, value}

    localparam logic [AW:0]      OCC_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      OCC_ONE   = (AW+1)'(1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [WIDTH-1:0] COUNT_MIN = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_TAG,
        ST_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Change detector
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_count_reg;
    logic             prev_valid_reg;
    logic             event_valid;
    logic             event_tag;
    logic             wrap_pulse_reg;

    // Event when an enabled sample differs from the last enabled sample.
    always_comb begin
        event_valid = sample_en && prev_valid_reg && (count != prev_count_reg);
        event_tag   = (prev_count_reg == COUNT_MAX) && (count == COUNT_MIN);
    end

    // Remember the last enabled sample. The first sample after reset only primes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_count_reg <= '0;
            prev_valid_reg <= 1'b0;
        end else if (sample_en) begin
            prev_count_reg <= count;
            prev_valid_reg <= 1'b1;
        end
    end

    // One-cycle wrap indication. It fires even if the FIFO drops the event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap_pulse_reg <= 1'b0;
        end else begin
            wrap_pulse_reg <= event_valid && event_tag;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   occ_reg;
    logic [AW:0]   occ_next;
    logic          empty_reg;
    logic          full_reg;
    logic          overflow_reg;
    logic          full_now;
    logic          push;
    logic          pop;
    logic [EW-1:0] rd_data;

    // Accept an event unless the FIFO is full with no pop at the same edge.
    always_comb begin
        full_now = (occ_reg == OCC_FULL);
        push     = event_valid && (!full_now || pop);
        rd_data  = mem[rd_ptr_reg];
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + OCC_ONE;
            2'b01:   occ_next = occ_reg - OCC_ONE;
            default: occ_next = occ_reg;
        endcase
    end

    // Storage array. Reset does not clear it; flushing the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {event_tag, count};
        end
    end

    // Pointers, occupancy, registered flags and the sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            occ_reg   <= occ_next;
            empty_reg <= (occ_next == '0);
            full_reg  <= (occ_next == OCC_FULL);
            if (event_valid && full_now && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serial transmitter
    // ------------------------------------------------------------------
    tx_state_t        state_reg,   state_next;
    logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [IW-1:0]    idx_reg,     idx_next;
    logic [WIDTH-1:0] data_reg,    data_next;
    logic             tag_reg,     tag_next;
    logic             tx_reg,      tx_next;
    logic             busy_reg,    busy_next;
    logic             bit_end;

    // Next-state logic. tx_next is the line level for the state being entered,
    // so the line changes on the same edge as the state.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        idx_next     = idx_reg;
        data_next    = data_reg;
        tag_next     = tag_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        bit_end      = (bit_cnt_reg == CNT_LAST);

        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (occ_reg != '0) begin
                    pop          = 1'b1;
                    data_next    = rd_data[WIDTH-1:0];
                    tag_next     = rd_data[WIDTH];
                    bit_cnt_next = '0;
                    idx_next     = '0;
                    tx_next      = 1'b0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    idx_next     = '0;
                    tx_next      = data_reg[0];
                    state_next   = ST_DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        tx_next    = tag_reg;
                        state_next = ST_TAG;
                    end else begin
                        // Shift so that the next bit to send is always at bit 0.
                        data_next = data_reg >> 1;
                        tx_next   = data_next[0];
                        idx_next  = idx_reg + IDX_ONE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_ONE;
                end
            end
            ST_TAG: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    tx_next      = 1'b1;
                    state_next   = ST_STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Always return through IDLE. This gives one idle cycle between frames.
                    bit_cnt_next = '0;
                    tx_next      = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_ONE;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // Transmitter state register. A reset in the middle of a frame aborts it
    // and returns the line high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            idx_reg     <= '0;
            data_reg    <= '0;
            tag_reg     <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            idx_reg     <= idx_next;
            data_reg    <= data_next;
            tag_reg     <= tag_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_out     = tx_reg;
    assign tx_busy    = busy_reg;
    assign fifo_empty = empty_reg;
    assign fifo_full  = full_reg;
    assign overflow   = overflow_reg;
    assign wrap_pulse = wrap_pulse_reg;

endmodule

// File: tb/tb_count_event_tx.sv
// Testbench for count_event_tx.
// The stimulus queues the frames it expects. A monitor decodes frames from
// tx_out and checks them against that queue.
module tb_count_event_tx;

    localparam int WIDTH      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CYCLES = 4;
    localparam int FRAME      = (WIDTH + 3) * BIT_CYCLES;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic [WIDTH-1:0] count     = '0;
    logic             sample_en = 1'b0;
    logic             tx_out;
    logic             tx_busy;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow;
    logic             wrap_pulse;

    int         n_checks    = 0;
    int         n_pass      = 0;
    logic [4:0] exp_q[$];
    logic       mon_en      = 1'b1;
    logic       capturing   = 1'b0;
    int         wrap_seen   = 0;
    int         frames_seen = 0;

    always #5 clk = ~clk;

    count_event_tx #(
        .WIDTH(WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BIT_CYCLES(BIT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .count(count),
        .sample_en(sample_en),
        .tx_out(tx_out),
        .tx_busy(tx_busy),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .wrap_pulse(wrap_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until every queued frame has been seen and the line is idle.
    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || capturing || tx_busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain_in_time"}, (t < 2000) ? 32'd1 : 32'd0, 32'd1);
        step(2);
    endtask

    // Count wrap pulses seen on any cycle.
    always @(negedge clk) begin
        if (wrap_pulse === 1'b1) wrap_seen++;
    end

    // Monitor: decode each frame and compare it with the oldest queued event.
    initial begin : monitor
        logic             prev_tx;
        logic             busy_ok;
        logic [FRAME-1:0] act_tx;
        logic [FRAME-1:0] exp_tx;
        logic [4:0]       ev;
        int               seg;
        prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && prev_tx === 1'b1 && tx_out === 1'b0) begin
                capturing = 1'b1;
                busy_ok   = 1'b1;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clk);
                    act_tx[i] = tx_out;
                    if (tx_busy !== 1'b1) busy_ok = 1'b0;
                end
                @(negedge clk);
                frames_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got bits %0h, required no frame", act_tx);
                end else begin
                    ev = exp_q.pop_front();
                    for (int i = 0; i < FRAME; i++) begin
                        seg = i / BIT_CYCLES;
                        if (seg == 0)               exp_tx[i] = 1'b0;
                        else if (seg <= WIDTH)      exp_tx[i] = ev[seg-1];
                        else if (seg == WIDTH + 1)  exp_tx[i] = ev[WIDTH];
                        else                        exp_tx[i] = 1'b1;
                    end
                    $display("frame: data=%h tag=%b bits=%07h", ev[3:0], ev[4], act_tx);
                    check("frame_bits", 32'(act_tx), 32'(exp_tx));
                    check("frame_busy_high", 32'(busy_ok), 32'd1);
                    check("frame_end_idle", {30'd0, tx_out, tx_busy}, 32'd2);
                end
                capturing = 1'b0;
            end
            prev_tx = tx_out;
        end
    end

    // Stimulus
    initial begin : stim
        int bad;
        int f0;

        // Hold reset for two edges.
        reset     = 1'b0;
        count     = 4'd5;
        sample_en = 1'b1;
        step(2);
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wrap", 32'(wrap_pulse), 32'd0);
        reset = 1'b1;

        // Test 1: count held at a constant value produces no frames.
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b1) bad++;
        end
        check("t1_quiet", 32'(bad), 32'd0);
        $display("t1: constant count, %0d bad cycles", bad);

        // Test 2: 5 -> 6 gives one frame with no wrap.
        count = 4'd6;
        exp_q.push_back(5'h06);
        @(negedge clk);
        check("t2_queued", {30'd0, fifo_empty, tx_out}, 32'd1);
        @(negedge clk);
        check("t2_start_latency", {30'd0, tx_out, tx_busy}, 32'd1);
        drain("t2");
        check("t2_no_wrap", 32'(wrap_seen), 32'd0);

        // Test 3: go to 15, then wrap to 0.
        count = 4'd15;
        exp_q.push_back(5'h0F);
        drain("t3a");
        count = 4'd0;
        exp_q.push_back(5'h10);
        @(negedge clk);
        check("t3_wrap_high", 32'(wrap_pulse), 32'd1);
        @(negedge clk);
        check("t3_wrap_low", 32'(wrap_pulse), 32'd0);
        drain("t3b");
        check("t3_wrap_count", 32'(wrap_seen), 32'd1);

        // Test 4: count increments every clock, filling the FIFO, then overflows.
        for (int v = 1; v <= 5; v++) begin
            count = 4'(v);
            exp_q.push_back({1'b0, 4'(v)});
            if (v == 5) check("t4_not_full_before_5", 32'(fifo_full), 32'd0);
            @(negedge clk);
        end
        check("t4_full_after_5", 32'(fifo_full), 32'd1);
        check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        count = 4'd6;
        @(negedge clk);
        check("t4_overflow_set", 32'(overflow), 32'd1);
        drain("t4");
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Test 5: reset during DATA with two events still queued.
        mon_en = 1'b0;
        count = 4'd7;
        @(negedge clk);
        count = 4'd8;
        @(negedge clk);
        count = 4'd9;
        @(negedge clk);
        step(6);
        check("t5_busy_before_rst", 32'(tx_busy), 32'd1);
        check("t5_queued_before_rst", 32'(fifo_empty), 32'd0);
        reset = 1'b0;
        count = 4'd10;
        @(negedge clk);
        check("t5_rst_tx_out", 32'(tx_out), 32'd1);
        check("t5_rst_tx_busy", 32'(tx_busy), 32'd0);
        check("t5_rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("t5_rst_overflow", 32'(overflow), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || fifo_empty !== 1'b1) bad++;
        end
        check("t5_no_frame_after_release", 32'(bad), 32'd0);
        $display("t5: reset mid-frame, %0d bad cycles after release", bad);

        // Test 6: changes while disabled give a single event when re-enabled.
        sample_en = 1'b0;
        count = 4'd3;
        @(negedge clk);
        count = 4'd7;
        @(negedge clk);
        count = 4'd9;
        @(negedge clk);
        check("t6_nothing_while_disabled", 32'(fifo_empty), 32'd1);
        f0 = frames_seen;
        sample_en = 1'b1;
        exp_q.push_back(5'h09);
        drain("t6");
        step(40);
        check("t6_one_frame", 32'(frames_seen - f0), 32'd1);

        check("all_expected_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Stop the run if it goes far past the expected length.
    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
